// File: rtl/seg7_display_arbiter.sv
// Arbitrates one 4-digit multiplexed 7-segment display among three requesters
// (fixed priority, minimum hold before preemption), plus digit scan and hex decode.
module seg7_display_arbiter #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 500,
  parameter int unsigned HOLD_CYC  = 25000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req_i,
  input  logic [15:0] data0_i,
  input  logic [15:0] data1_i,
  input  logic [15:0] data2_i,
  output logic [2:0]  gnt_o,
  output logic [3:0]  led_cs_o,
  output logic [7:0]  led_db_o
);

  localparam int unsigned SCAN_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned HOLD_BITS = $clog2(HOLD_CYC + 1);
  localparam int unsigned HOLD_W    = (HOLD_BITS > 25) ? HOLD_BITS : 25;

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [SCAN_W-1:0] BLANK_END = SCAN_W'(BLANK_CYC);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    SWITCH = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [1:0]        digit_q, digit_d;
  logic [2:0]        gnt_q, gnt_d;
  logic [3:0]        led_cs_q, led_cs_d;
  logic [7:0]        led_db_q, led_db_d;

  logic              owner_req_s;
  logic              higher_req_s;
  logic [15:0]       owner_data_s;
  logic [3:0]        nibble_s;

  function automatic logic [1:0] top_req(input logic [2:0] r);
    logic [1:0] idx;
    if (r[0]) begin
      idx = 2'd0;
    end else if (r[1]) begin
      idx = 2'd1;
    end else begin
      idx = 2'd2;
    end
    return idx;
  endfunction

  function automatic logic req_of(input logic [2:0] r, input logic [1:0] who);
    logic hit;
    case (who)
      2'd0:    hit = r[0];
      2'd1:    hit = r[1];
      2'd2:    hit = r[2];
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  // True when some requester above the current owner is asking.
  function automatic logic higher_of(input logic [2:0] r, input logic [1:0] who);
    logic hit;
    case (who)
      2'd0:    hit = 1'b0;
      2'd1:    hit = r[0];
      2'd2:    hit = r[0] | r[1];
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] who);
    logic [2:0] oh;
    case (who)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  function automatic logic [3:0] digit_sel(input logic [1:0] dig);
    logic [3:0] cs;
    case (dig)
      2'd0:    cs = 4'b1110;
      2'd1:    cs = 4'b1101;
      2'd2:    cs = 4'b1011;
      2'd3:    cs = 4'b0111;
      default: cs = 4'b1111;
    endcase
    return cs;
  endfunction

  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0:    seg = 8'hC0;
      4'h1:    seg = 8'hF9;
      4'h2:    seg = 8'hA4;
      4'h3:    seg = 8'hB0;
      4'h4:    seg = 8'h99;
      4'h5:    seg = 8'h92;
      4'h6:    seg = 8'h82;
      4'h7:    seg = 8'hF8;
      4'h8:    seg = 8'h80;
      4'h9:    seg = 8'h90;
      4'hA:    seg = 8'h88;
      4'hB:    seg = 8'h83;
      4'hC:    seg = 8'hC6;
      4'hD:    seg = 8'hA1;
      4'hE:    seg = 8'h86;
      4'hF:    seg = 8'h8E;
      default: seg = 8'hFF;
    endcase
    return seg;
  endfunction

  // Owner-related request decode and live data nibble selection.
  always_comb begin
    owner_req_s  = req_of(req_i, owner_q);
    higher_req_s = higher_of(req_i, owner_q);
    case (owner_q)
      2'd0:    owner_data_s = data0_i;
      2'd1:    owner_data_s = data1_i;
      2'd2:    owner_data_s = data2_i;
      default: owner_data_s = 16'h0000;
    endcase
    case (digit_q)
      2'd0:    nibble_s = owner_data_s[3:0];
      2'd1:    nibble_s = owner_data_s[7:4];
      2'd2:    nibble_s = owner_data_s[11:8];
      2'd3:    nibble_s = owner_data_s[15:12];
      default: nibble_s = 4'h0;
    endcase
  end

  // Arbitration next state; higher requests seen during hold are not remembered.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (req_i != 3'b000) begin
          state_d = GRANT;
          owner_d = top_req(req_i);
          hold_d  = HOLD_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (!owner_req_s) begin
          state_d = SWITCH;
        end else if ((hold_q == HOLD_ZERO) && higher_req_s) begin
          state_d = SWITCH;
        end else begin
          state_d = GRANT;
        end
        if (hold_q == HOLD_ZERO) begin
          hold_d = HOLD_ZERO;
        end else begin
          hold_d = hold_q - HOLD_ONE;
        end
      end
      SWITCH: begin
        if (req_i != 3'b000) begin
          state_d = GRANT;
          owner_d = top_req(req_i);
          hold_d  = HOLD_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Free-running digit scan, independent of arbitration.
  always_comb begin
    if (scan_q == SCAN_LAST) begin
      scan_d  = {SCAN_W{1'b0}};
      digit_d = digit_q + 2'd1;
    end else begin
      scan_d  = scan_q + SCAN_W'(1);
      digit_d = digit_q;
    end
  end

  // Output images of the current state, registered on the next edge.
  always_comb begin
    gnt_d    = 3'b000;
    led_cs_d = 4'b1111;
    led_db_d = 8'hFF;
    if (state_q == GRANT) begin
      gnt_d = onehot(owner_q);
      if (scan_q >= BLANK_END) begin
        led_cs_d = digit_sel(digit_q);
        led_db_d = seg_decode(nibble_s);
      end else begin
        led_cs_d = 4'b1111;
        led_db_d = 8'hFF;
      end
    end else begin
      gnt_d = 3'b000;
    end
  end

  // State, scan and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= 2'd0;
      hold_q   <= HOLD_ZERO;
      scan_q   <= {SCAN_W{1'b0}};
      digit_q  <= 2'd0;
      gnt_q    <= 3'b000;
      led_cs_q <= 4'b1111;
      led_db_q <= 8'hFF;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      hold_q   <= hold_d;
      scan_q   <= scan_d;
      digit_q  <= digit_d;
      gnt_q    <= gnt_d;
      led_cs_q <= led_cs_d;
      led_db_q <= led_db_d;
    end
  end

  assign gnt_o    = gnt_q;
  assign led_cs_o = led_cs_q;
  assign led_db_o = led_db_q;

endmodule

// File: doc/seg7_display_arbiter.md
Name: seg7_display_arbiter

Overview:
Shares the board's single 4-digit multiplexed 7-segment display among three requesters: the IR decoder, the debug counter and the status monitor. The block grants the display using fixed priority, with a minimum hold time before preemption. It also runs the digit scan and decodes hex nibbles to active-low segment patterns. It sits between the requester blocks and the led_cs/led_db pins.

Parameters:
SCAN_DIV, 50000, clk cycles per digit slot (1 ms at 50 MHz); must be >= 2.
BLANK_CYC, 500, cycles at the start of each slot with all digits off (ghosting suppression); must be < SCAN_DIV.
HOLD_CYC, 25000000, minimum cycles an owner keeps the grant before a higher-priority requester can preempt it; counter width >= 25 bits.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
req  in  3  display requests; bit 0 has highest priority, bit 2 lowest
data0  in  16  requester 0 hex value; [3:0] is the rightmost digit
data1  in  16  requester 1 hex value
data2  in  16  requester 2 hex value
gnt  out  3  one-hot grant, or all-zero when no owner
led_cs  out  4  digit selects, active-low
led_db  out  8  segments, active-low; bit 7 = dp, g..a = bits 6..0

Behaviour:
- Reset values: state=IDLE, gnt=000, scan_cnt=0, digit=0, hold_cnt=0, led_cs=4'b1111, led_db=8'hFF. All outputs are registered.
- FSM states: IDLE, GRANT, SWITCH.
- IDLE:
  - If req!=0, move to GRANT on the next edge.
  - Set gnt to the highest-priority set bit and load hold_cnt=HOLD_CYC.
  - Latency: req is sampled at edge N, and gnt is visible after edge N+1.
- GRANT:
  - hold_cnt decrements each cycle and saturates at 0.
  - Owner deasserts its req: go to SWITCH immediately, regardless of hold_cnt.
  - hold_cnt==0 and a higher-priority req is set: go to SWITCH (preemption).
  - Lower-priority requests never preempt.
  - Requests from higher-priority requesters during the hold time are not stored; they must still be asserted when hold_cnt reaches 0.
- SWITCH:
  - Lasts exactly 1 cycle with gnt=000.
  - Then go to GRANT with the highest-priority pending req, reloading hold_cnt, or go to IDLE if req==0.
  - When the owner drops its req and the same requester reasserts in the SWITCH cycle, it is re-granted.
- Scan:
  - scan_cnt runs freely 0..SCAN_DIV-1 in every state and is not reset by arbitration.
  - At scan_cnt==SCAN_DIV-1, digit increments 0->1->2->3->0.
- Outputs (registered from the current-cycle state/scan_cnt/digit):
  - state==GRANT and scan_cnt>=BLANK_CYC: led_cs is low on bit [digit] only (digit0=1110, digit1=1101, digit2=1011, digit3=0111), and led_db = decode(owner data nibble [4*digit+3:4*digit]).
  - Otherwise (blank window, IDLE or SWITCH): led_cs=1111 and led_db=8'hFF.
  - Owner data is live (not latched); a change shows in the next visible cycle.
- Decode table (dp off):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, B=83, C=C6, D=A1, E=86, F=8E
- Reset mid-operation: when rst_n is low at an edge, all state returns to reset values at that edge, including during GRANT or mid-slot.
- gnt is never multi-hot, and never changes directly from one owner to another without passing through the all-zero SWITCH cycle.

Test Plan:
All tests use SCAN_DIV=8, BLANK_CYC=2, HOLD_CYC=20.
1. Reset/idle: hold rst_n=0 for 3 cycles, then keep req=000 for 100 cycles -> gnt=000, led_cs=1111 and led_db=FF every cycle.
2. Single owner scan:
   - Stimulus: req=100, data2=16'h1A3F.
   - Grant: gnt=100 one cycle after req is sampled.
   - Slot pattern: each 8-cycle slot shows 2 cycles of 1111, then 6 cycles of the digit select.
   - Digit order and segments: 1110/8E, 1101/B0, 1011/88, 0111/F9, then wrap back to 1110.
3. Hold then preempt:
   - req=100 is granted; req[0] rises 5 cycles later with data0=16'h0000.
   - gnt stays 100 until hold_cnt reaches 0, then goes 000 for one cycle, then 001.
   - Visible digits then show C0.
4. Release: owner 001 drops req while req=110 -> one SWITCH cycle with gnt=000, then gnt=010; the hold time does not delay the release.
5. Lower priority ignored: owner 010 with hold expired; req[2] pulses for 30 cycles -> gnt stays 010 and no SWITCH occurs.
6. Reset mid-grant: assert rst_n=0 at scan_cnt=5 of digit 2 -> the next cycle has gnt=000, led_cs=1111, led_db=FF, and the scan restarts at digit 0.
